dmem_arbiter: RTL
=================

# dmem_arbiter

Two-requester arbiter sharing the single-port data memory between the core load/store path and the program/data loader. Accepted requests are registered onto the DMEM port. Every accepted request returns exactly one response to its originator two cycles after acceptance. Sits between the Control_Unit/ALU load-store path, the loader, and DMEM.

## Interface
- AW, 32, address width
- DW, 32, data width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- c_valid  in  1  core request valid
- c_ready  out  1  core request accepted this cycle; core stalls while c_valid && !c_ready
- c_we  in  1  core write (1) / read (0)
- c_addr  in  AW  core byte address
- c_wdata  in  DW  core store data
- c_wsel  in  2  store size, DMEM WSel encoding
- c_rsel  in  3  load size/sign, DMEM RSel encoding
- c_rsp_valid  out  1  core response strobe
- c_rsp_rdata  out  DW  core load data; 0 for writes
- l_valid, l_ready, l_we, l_addr, l_wdata, l_wsel, l_rsel, l_rsp_valid, l_rsp_rdata: loader copies of the core ports
- l_lock  in  1  loader requests to keep the grant on following cycles
- m_we  out  1  DMEM write enable (dmem_sel)
- m_addr  out  AW  DMEM address
- m_wdata  out  DW  DMEM write data
- m_wsel  out  2  DMEM WSel
- m_rsel  out  3  DMEM RSel
- m_rdata  in  DW  DMEM read data, combinational from m_addr/m_rsel

## Operation
- Acceptance: at most one request per cycle. Ready asserts only for the granted requester, and only while its valid is high. Ready is combinational from valids and arbiter state.
- Arbitration: round-robin (see Configuration). After a grant to X, the last-grant pointer moves to X; on the next contest the other requester wins.
- Lock: if the loader was granted last cycle and l_lock && l_valid now, the loader wins regardless of pointer. If the loader holds lock for 16 consecutive grants, lock is ignored for one cycle while c_valid is high. Use a 4-bit counter, cleared on any core grant.
- Stage 1 (cycle N+1): the accepted request is registered onto m_*. m_we is asserted only for writes and only in that cycle; otherwise m_we = 0. m_addr, m_wsel, m_rsel and m_wdata hold their last value while idle.
- Stage 2: tag register {valid, id, we} follows stage 1. At the end of N+1, m_rdata is captured when the tag is a read, else 0 is captured. During N+2, the matching *_rsp_valid pulses for one cycle with the captured data.
- No response backpressure: requesters must take responses in the pulse cycle.
- Ordering: in acceptance order. A read issued after a write to the same address returns the written data; no hazard logic is needed with a single port.

## Timing
- Reset (rst low, asynchronous): m_we=0, m_addr=0, m_wdata=0, m_wsel=0, m_rsel=0, *_rsp_valid=0, *_rsp_rdata=0, pointer=core-last (loader wins first contest), lock counter=0, stage valids=0.
- In-flight transactions are dropped at reset. No response is issued for them.
- Latency: accept in N, DMEM access in N+1, response in N+2. Throughput 1/cycle; back-to-back accepts from either side are pipelined.
- Simultaneous valids with no lock: the requester not granted last wins. The loser's ready=0, and it must hold its request stable.
- Withdrawing valid without acceptance is legal.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin plus lock as above.
- Undefined: fixed priority, core over loader. The pointer register is removed. l_lock still holds a loader grant, but the 16-grant limit always applies, so the core is never starved beyond 16 cycles.

## Structure
- Package dmem_arb_pkg holds:
  - requester ID constants CORE_ID=0, LDR_ID=1
  - WSEL_W=2, RSEL_W=3
  - LOCK_MAX=16
  - a packed request struct {we, addr, wdata, wsel, rsel}
- Sub-module arb2_rr: 2-way grant logic (pointer, lock, lock counter, fixed-priority variant under the macro). The top holds the stage registers and response demux.

## Test plan
- Reset mid-transfer: core write to 0x10 accepted, rst pulsed low in N+1 -> m_we falls asynchronously, no c_rsp_valid, all outputs at reset values.
- Core SW 0xDEADBEEF to 0x20 in N, LW from 0x20 in N+1 -> m_we=1 in N+1 only; c_rsp_valid in N+2 (rdata 0) and N+3 (rdata 0xDEADBEEF).
- Both valid every cycle, no lock, RR build -> grants alternate L,C,L,C. Each response reaches the correct side with the correct data.
- Loader l_lock held with c_valid high -> 16 loader grants, then 1 core grant, then the loader regains the grant.
- Fixed-priority build (macro undefined), both valid, no lock -> core granted every cycle; loader ready stays 0.
- Loader LB (sign-extend rsel) from a byte holding 0x80 -> l_rsp_rdata=0xFFFFFF80 two cycles after acceptance; c_rsp_valid stays 0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the DMEM arbiter.
package dmem_arb_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned WSEL_W     = 2;
  localparam int unsigned RSEL_W     = 3;
  localparam int unsigned LOCK_MAX   = 16;
  localparam int unsigned LOCK_CNT_W = $clog2(LOCK_MAX);

  localparam logic CORE_ID = 1'b0;
  localparam logic LDR_ID  = 1'b1;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [WSEL_W-1:0] wsel;
    logic [RSEL_W-1:0] rsel;
  } req_t;

endpackage

// File: rtl/arb2_rr.sv
// Two-way grant logic: round-robin with loader lock when DMEM_ARB_RR_EN is defined,
// otherwise fixed core-over-loader priority with the same bounded loader lock.
module arb2_rr
  import dmem_arb_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_c_valid,
  input  logic i_l_valid,
  input  logic i_l_lock,
  output logic o_gnt_c,
  output logic o_gnt_l
);

  logic                  r_ldr_last;
  logic [LOCK_CNT_W-1:0] r_lock_cnt;
  logic                  w_lock_full;
  logic                  w_lock_hold;

  // r_lock_cnt counts consecutive loader grants beyond the first one.
  assign w_lock_full = (r_lock_cnt == LOCK_CNT_W'(LOCK_MAX - 1));
  assign w_lock_hold = r_ldr_last && i_l_lock && i_l_valid && !(w_lock_full && i_c_valid);

`ifdef DMEM_ARB_RR_EN
  logic r_ptr_ldr;

  always_comb begin
    o_gnt_c = 1'b0;
    o_gnt_l = 1'b0;
    if (w_lock_hold) begin
      o_gnt_l = 1'b1;
    end else if (i_c_valid && i_l_valid) begin
      o_gnt_c = r_ptr_ldr;
      o_gnt_l = !r_ptr_ldr;
    end else begin
      o_gnt_c = i_c_valid;
      o_gnt_l = i_l_valid;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr_ldr <= 1'b0;
    end else if (o_gnt_c) begin
      r_ptr_ldr <= 1'b0;
    end else if (o_gnt_l) begin
      r_ptr_ldr <= 1'b1;
    end
  end
`else
  always_comb begin
    o_gnt_c = 1'b0;
    o_gnt_l = 1'b0;
    if (w_lock_hold) begin
      o_gnt_l = 1'b1;
    end else if (i_c_valid) begin
      o_gnt_c = 1'b1;
    end else begin
      o_gnt_l = i_l_valid;
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ldr_last <= 1'b0;
      r_lock_cnt <= '0;
    end else begin
      r_ldr_last <= o_gnt_l;
      if (o_gnt_c) begin
        r_lock_cnt <= '0;
      end else if (o_gnt_l) begin
        if (!r_ldr_last) begin
          r_lock_cnt <= '0;
        end else if (!w_lock_full) begin
          r_lock_cnt <= r_lock_cnt + LOCK_CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Core/loader arbiter onto the single-port DMEM: accept in N, DMEM access in N+1, response
// in N+2. Round-robin arbitration is enabled by DMEM_ARB_RR_EN (see arb2_rr).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW = ADDR_W,
  parameter int unsigned DW = DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_c_valid,
  output logic              o_c_ready,
  input  logic              i_c_we,
  input  logic [AW-1:0]     i_c_addr,
  input  logic [DW-1:0]     i_c_wdata,
  input  logic [WSEL_W-1:0] i_c_wsel,
  input  logic [RSEL_W-1:0] i_c_rsel,
  output logic              o_c_rsp_valid,
  output logic [DW-1:0]     o_c_rsp_rdata,
  input  logic              i_l_valid,
  output logic              o_l_ready,
  input  logic              i_l_we,
  input  logic [AW-1:0]     i_l_addr,
  input  logic [DW-1:0]     i_l_wdata,
  input  logic [WSEL_W-1:0] i_l_wsel,
  input  logic [RSEL_W-1:0] i_l_rsel,
  input  logic              i_l_lock,
  output logic              o_l_rsp_valid,
  output logic [DW-1:0]     o_l_rsp_rdata,
  output logic              o_m_we,
  output logic [AW-1:0]     o_m_addr,
  output logic [DW-1:0]     o_m_wdata,
  output logic [WSEL_W-1:0] o_m_wsel,
  output logic [RSEL_W-1:0] o_m_rsel,
  input  logic [DW-1:0]     i_m_rdata
);

  logic    w_gnt_c;
  logic    w_gnt_l;
  logic    w_accept;
  req_t    w_req;

  logic    r_s1_valid;
  logic    r_s1_id;
  logic    r_s1_we;
  logic    r_rsp_valid;
  logic    r_rsp_id;
  logic [DW-1:0] r_rsp_rdata;

  arb2_rr u_arb (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_c_valid (i_c_valid),
    .i_l_valid (i_l_valid),
    .i_l_lock  (i_l_lock),
    .o_gnt_c   (w_gnt_c),
    .o_gnt_l   (w_gnt_l)
  );

  assign o_c_ready = w_gnt_c & i_c_valid;
  assign o_l_ready = w_gnt_l & i_l_valid;
  assign w_accept  = o_c_ready | o_l_ready;

  always_comb begin
    w_req = '{we: i_c_we, addr: i_c_addr, wdata: i_c_wdata, wsel: i_c_wsel, rsel: i_c_rsel};
    if (o_l_ready) begin
      w_req = '{we: i_l_we, addr: i_l_addr, wdata: i_l_wdata, wsel: i_l_wsel, rsel: i_l_rsel};
    end
  end

  // Stage 1: drive DMEM; address/data/selects hold while idle, write enable pulses once.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_m_we     <= 1'b0;
      o_m_addr   <= '0;
      o_m_wdata  <= '0;
      o_m_wsel   <= '0;
      o_m_rsel   <= '0;
      r_s1_valid <= 1'b0;
      r_s1_id    <= CORE_ID;
      r_s1_we    <= 1'b0;
    end else begin
      o_m_we     <= w_accept & w_req.we;
      r_s1_valid <= w_accept;
      if (w_accept) begin
        o_m_addr  <= w_req.addr;
        o_m_wdata <= w_req.wdata;
        o_m_wsel  <= w_req.wsel;
        o_m_rsel  <= w_req.rsel;
        r_s1_id   <= o_l_ready ? LDR_ID : CORE_ID;
        r_s1_we   <= w_req.we;
      end
    end
  end

  // Stage 2: capture read data (0 for writes) and steer the response pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= CORE_ID;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= r_s1_valid;
      r_rsp_id    <= r_s1_id;
      r_rsp_rdata <= (r_s1_valid && !r_s1_we) ? i_m_rdata : '0;
    end
  end

  assign o_c_rsp_valid = r_rsp_valid && (r_rsp_id == CORE_ID);
  assign o_l_rsp_valid = r_rsp_valid && (r_rsp_id == LDR_ID);
  assign o_c_rsp_rdata = o_c_rsp_valid ? r_rsp_rdata : '0;
  assign o_l_rsp_rdata = o_l_rsp_valid ? r_rsp_rdata : '0;

endmodule
